// File: rtl/track_section_arbiter.sv
// track_section_arbiter
// Round-robin owner of one shared single-track section. A granted train is
// held while the junction switches settle, then released. Occupancy is
// bounded by a timeout, and any unexpected exit locks the section out until
// an operator clears the fault. All outputs come straight from registers.
module track_section_arbiter #(
    parameter int NUM_TRAINS     = 4,
    parameter int SW_WIDTH       = 3,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                           Clock,
    input  logic                           RESET,
    input  logic [NUM_TRAINS-1:0]          SR_REQ,
    input  logic [NUM_TRAINS-1:0]          SR_EXIT,
    input  logic [NUM_TRAINS*SW_WIDTH-1:0] SW_TABLE,
    input  logic                           FAULT_CLR,
    output logic [SW_WIDTH-1:0]            SW,
    output logic [2*NUM_TRAINS-1:0]        D,
    output logic [$clog2(NUM_TRAINS)-1:0]  GRANT_ID,
    output logic                           BUSY,
    output logic                           FAULT
);

    localparam int GW  = $clog2(NUM_TRAINS);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OCC    = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [GW-1:0]             ptr_r;
    logic [GW-1:0]             ptr_nxt_s;
    logic [GW-1:0]             grant_r;
    logic [GW-1:0]             grant_nxt_s;
    logic [SW_WIDTH-1:0]       sw_r;
    logic [SW_WIDTH-1:0]       sw_nxt_s;
    logic [2*NUM_TRAINS-1:0]   d_r;
    logic [2*NUM_TRAINS-1:0]   d_nxt_s;
    logic                      busy_r;
    logic                      busy_nxt_s;
    logic                      fault_r;
    logic                      fault_nxt_s;
    logic [SCW-1:0]            settle_cnt_r;
    logic [SCW-1:0]            settle_nxt_s;
    logic [TCW-1:0]            tmo_cnt_r;
    logic [TCW-1:0]            tmo_nxt_s;
    logic [TCW-1:0]            tmo_inc_s;
    logic [GW-1:0]             sel_s;
    logic [GW-1:0]             sel_idx_s;
    logic [NUM_TRAINS-1:0]     grant_mask_s;
    logic                      own_exit_s;
    logic                      foreign_exit_s;
    logic                      settle_done_s;

    assign SW       = sw_r;
    assign D        = d_r;
    assign GRANT_ID = grant_r;
    assign BUSY     = busy_r;
    assign FAULT    = fault_r;

    // Decode exits against the current grant and precompute counter steps
    always_comb begin
        grant_mask_s   = {{(NUM_TRAINS-1){1'b0}}, 1'b1} << grant_r;
        own_exit_s     = |(SR_EXIT & grant_mask_s);
        foreign_exit_s = |(SR_EXIT & ~grant_mask_s);
        tmo_inc_s      = tmo_cnt_r + TCW'(1);
        settle_done_s  = (settle_cnt_r <= SCW'(1));
    end

    // Round-robin pick: scan downwards so the lowest offset from ptr wins
    always_comb begin
        sel_s     = ptr_r;
        sel_idx_s = ptr_r;
        for (int k = NUM_TRAINS - 1; k >= 0; k--) begin
            sel_idx_s = GW'((int'(ptr_r) + k) % NUM_TRAINS);
            if (SR_REQ[sel_idx_s]) begin
                sel_s = sel_idx_s;
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Next-state logic; a foreign exit outranks the granted train's own exit,
    // and the granted train's exit outranks the timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|SR_REQ) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done_s) begin
                    state_nxt_s = ST_OCC;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_OCC: begin
                if (foreign_exit_s) begin
                    state_nxt_s = ST_FAULT;
                end else if (own_exit_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (tmo_inc_s == TCW'(TIMEOUT_CYCLES)) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_OCC;
                end
            end
            ST_FAULT: begin
                if (FAULT_CLR) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s = ST_FAULT;
            end
        endcase
    end

    // Output/datapath logic: values every register takes on the coming edge
    always_comb begin
        ptr_nxt_s    = ptr_r;
        grant_nxt_s  = grant_r;
        sw_nxt_s     = sw_r;
        settle_nxt_s = settle_cnt_r;
        tmo_nxt_s    = tmo_cnt_r;
        d_nxt_s      = '0;
        case (state_r)
            ST_IDLE: begin
                if (|SR_REQ) begin
                    grant_nxt_s  = sel_s;
                    sw_nxt_s     = SW_TABLE[sel_s*SW_WIDTH +: SW_WIDTH];
                    settle_nxt_s = SCW'(SETTLE_CYCLES);
                end else begin
                    settle_nxt_s = settle_cnt_r;
                end
            end
            ST_SETTLE: begin
                if (settle_done_s) begin
                    settle_nxt_s = '0;
                    tmo_nxt_s    = '0;
                end else begin
                    settle_nxt_s = settle_cnt_r - SCW'(1);
                end
            end
            ST_OCC: begin
                if (state_nxt_s == ST_OCC) begin
                    tmo_nxt_s = tmo_inc_s;
                end else begin
                    tmo_nxt_s = '0;
                end
                if (state_nxt_s == ST_IDLE) begin
                    ptr_nxt_s = GW'((int'(grant_r) + 1) % NUM_TRAINS);
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            ST_FAULT: begin
                tmo_nxt_s = '0;
            end
            default: begin
                tmo_nxt_s    = '0;
                settle_nxt_s = '0;
            end
        endcase

        busy_nxt_s  = (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_OCC);
        fault_nxt_s = (state_nxt_s == ST_FAULT);

        for (int i = 0; i < NUM_TRAINS; i++) begin
            if (fault_nxt_s) begin
                d_nxt_s[2*i +: 2] = 2'b00;
            end else if (busy_nxt_s && (GW'(i) == grant_nxt_s)) begin
                if (state_nxt_s == ST_SETTLE) begin
                    d_nxt_s[2*i +: 2] = 2'b00;
                end else begin
                    d_nxt_s[2*i +: 2] = 2'b01;
                end
            end else if (SR_REQ[i]) begin
                d_nxt_s[2*i +: 2] = 2'b00;
            end else begin
                d_nxt_s[2*i +: 2] = 2'b01;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge Clock) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs, pointer and counters with synchronous reset
    always_ff @(posedge Clock) begin
        if (RESET) begin
            ptr_r        <= '0;
            grant_r      <= '0;
            sw_r         <= '0;
            d_r          <= {NUM_TRAINS{2'b01}};
            busy_r       <= 1'b0;
            fault_r      <= 1'b0;
            settle_cnt_r <= '0;
            tmo_cnt_r    <= '0;
        end else begin
            ptr_r        <= ptr_nxt_s;
            grant_r      <= grant_nxt_s;
            sw_r         <= sw_nxt_s;
            d_r          <= d_nxt_s;
            busy_r       <= busy_nxt_s;
            fault_r      <= fault_nxt_s;
            settle_cnt_r <= settle_nxt_s;
            tmo_cnt_r    <= tmo_nxt_s;
        end
    end

endmodule

// File: tb/tb_track_section_arbiter.sv
// Testbench for track_section_arbiter: directed vector table followed by
// randomized traffic compared against a phase/edge-count reference model.
module tb_track_section_arbiter;

    localparam int N   = 4;
    localparam int SWW = 3;
    localparam int ST  = 2;
    localparam int TO  = 8;

    logic             Clock;
    logic             RESET;
    logic [N-1:0]     SR_REQ;
    logic [N-1:0]     SR_EXIT;
    logic [N*SWW-1:0] SW_TABLE;
    logic             FAULT_CLR;
    logic [SWW-1:0]   SW;
    logic [2*N-1:0]   D;
    logic [1:0]       GRANT_ID;
    logic             BUSY;
    logic             FAULT;

    track_section_arbiter #(
        .NUM_TRAINS     (N),
        .SW_WIDTH       (SWW),
        .SETTLE_CYCLES  (ST),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clock     (Clock),
        .RESET     (RESET),
        .SR_REQ    (SR_REQ),
        .SR_EXIT   (SR_EXIT),
        .SW_TABLE  (SW_TABLE),
        .FAULT_CLR (FAULT_CLR),
        .SW        (SW),
        .D         (D),
        .GRANT_ID  (GRANT_ID),
        .BUSY      (BUSY),
        .FAULT     (FAULT)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  ex;
        logic        clr;
        logic [11:0] tbl;
        logic [7:0]  d;
        logic [2:0]  sw;
        logic [1:0]  gid;
        logic        busy;
        logic        flt;
        string       name;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: phase 0 idle, 1 settle, 2 occupied, 3 fault
    int          m_phase;
    int          m_ptr;
    int          m_grant;
    int          m_n;
    logic [2:0]  m_sw;

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] ex,
                       input logic clr, input logic [11:0] tbl, input logic [7:0] d,
                       input logic [2:0] sw, input logic [1:0] gid, input logic busy,
                       input logic flt, input string name);
        vec_t v;
        v.rst = rst; v.req = req; v.ex = ex; v.clr = clr; v.tbl = tbl;
        v.d = d; v.sw = sw; v.gid = gid; v.busy = busy; v.flt = flt; v.name = name;
        vq.push_back(v);
    endtask

    task automatic apply_edge(input logic rst, input logic [3:0] req, input logic [3:0] ex,
                              input logic clr, input logic [11:0] tbl);
        @(negedge Clock);
        RESET     = rst;
        SR_REQ    = req;
        SR_EXIT   = ex;
        FAULT_CLR = clr;
        SW_TABLE  = tbl;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got D=%b SW=%b GID=%0d BUSY=%b FAULT=%b required D=%b SW=%b GID=%0d BUSY=%b FAULT=%b",
                     name, act[14:7], act[6:4], act[3:2], act[1], act[0],
                     exp[14:7], exp[6:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [3:0] req, input logic [3:0] ex,
                              input logic clr, input logic [11:0] tbl, output logic [14:0] exp);
        logic [7:0]  d;
        logic [11:0] sh;
        int          g;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_grant = 0; m_sw = 3'b000; m_n = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (req != 4'b0000) begin
                        g = 0;
                        for (int k = 0; k < N; k++) begin
                            if (req[(m_ptr + k) % N]) begin
                                g = (m_ptr + k) % N;
                                break;
                            end
                        end
                        m_grant = g;
                        sh      = tbl >> (SWW * g);
                        m_sw    = sh[2:0];
                        m_phase = 1;
                        m_n     = 0;
                    end
                end
                1: begin
                    m_n++;
                    if (m_n == ST) begin
                        m_phase = 2;
                        m_n     = 0;
                    end
                end
                2: begin
                    m_n++;
                    if ((ex & ~(4'b0001 << m_grant)) != 4'b0000) m_phase = 3;
                    else if (ex[m_grant]) begin
                        m_phase = 0;
                        m_ptr   = (m_grant + 1) % N;
                    end else if (m_n == TO) m_phase = 3;
                end
                default: begin
                    if (clr) m_phase = 0;
                end
            endcase
        end
        for (int i = 0; i < N; i++) begin
            if (rst) d[2*i +: 2] = 2'b01;
            else if (m_phase == 3) d[2*i +: 2] = 2'b00;
            else if ((m_phase == 1 || m_phase == 2) && i == m_grant)
                d[2*i +: 2] = (m_phase == 1) ? 2'b00 : 2'b01;
            else d[2*i +: 2] = req[i] ? 2'b00 : 2'b01;
        end
        exp = {d, m_sw, 2'(m_grant), (m_phase == 1 || m_phase == 2), (m_phase == 3)};
    endtask

    initial begin
        logic [11:0] t1;
        logic [11:0] t2;
        logic [14:0] exp;
        logic [3:0]  rq;
        logic [3:0]  ex;
        logic        clr;
        logic        rst;
        logic [11:0] tbl;

        t1 = 12'b101_011_110_010;
        t2 = 12'b000_111_000_111;
        RESET = 1'b1; SR_REQ = 4'b0000; SR_EXIT = 4'b0000; FAULT_CLR = 1'b0; SW_TABLE = t1;

        // reset and basic grant of train 2
        add(1'b1, 4'b0000, 4'b0000, 1'b0, t1, 8'h55, 3'b000, 2'd0, 1'b0, 1'b0, "reset");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h55, 3'b000, 2'd0, 1'b0, 1'b0, "idle_noreq");
        add(1'b0, 4'b0100, 4'b0000, 1'b0, t1, 8'h45, 3'b011, 2'd2, 1'b1, 1'b0, "grant2");
        add(1'b0, 4'b0100, 4'b0000, 1'b0, t1, 8'h45, 3'b011, 2'd2, 1'b1, 1'b0, "settle2_a");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h55, 3'b011, 2'd2, 1'b1, 1'b0, "release2");
        add(1'b0, 4'b0000, 4'b0100, 1'b0, t1, 8'h55, 3'b011, 2'd2, 1'b0, 1'b0, "exit2");
        // round robin between trains 0 and 2
        add(1'b0, 4'b0101, 4'b0000, 1'b0, t1, 8'h44, 3'b010, 2'd0, 1'b1, 1'b0, "rr_grant0");
        add(1'b0, 4'b0101, 4'b0000, 1'b0, t1, 8'h44, 3'b010, 2'd0, 1'b1, 1'b0, "rr_settle0");
        add(1'b0, 4'b0101, 4'b0000, 1'b0, t1, 8'h45, 3'b010, 2'd0, 1'b1, 1'b0, "rr_occ0");
        add(1'b0, 4'b0101, 4'b0001, 1'b0, t1, 8'h44, 3'b010, 2'd0, 1'b0, 1'b0, "rr_exit0");
        add(1'b0, 4'b0101, 4'b0000, 1'b0, t1, 8'h44, 3'b011, 2'd2, 1'b1, 1'b0, "rr_grant2");
        add(1'b0, 4'b0101, 4'b0000, 1'b0, t1, 8'h44, 3'b011, 2'd2, 1'b1, 1'b0, "rr_settle2");
        add(1'b0, 4'b0101, 4'b0000, 1'b0, t1, 8'h54, 3'b011, 2'd2, 1'b1, 1'b0, "rr_occ2");
        add(1'b0, 4'b0000, 4'b0100, 1'b0, t1, 8'h55, 3'b011, 2'd2, 1'b0, 1'b0, "rr_exit2");
        // timeout on train 1
        add(1'b0, 4'b0010, 4'b0000, 1'b0, t1, 8'h51, 3'b110, 2'd1, 1'b1, 1'b0, "to_grant1");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h51, 3'b110, 2'd1, 1'b1, 1'b0, "to_settle1");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h55, 3'b110, 2'd1, 1'b1, 1'b0, "to_occ_entry");
        for (int i = 0; i < TO - 1; i++)
            add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h55, 3'b110, 2'd1, 1'b1, 1'b0, "to_occ");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h00, 3'b110, 2'd1, 1'b0, 1'b1, "timeout");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h00, 3'b110, 2'd1, 1'b0, 1'b1, "fault_hold");
        add(1'b0, 4'b0000, 4'b0000, 1'b1, t1, 8'h55, 3'b110, 2'd1, 1'b0, 1'b0, "fault_clr");
        // reset during settle restores pointer 0
        add(1'b0, 4'b0100, 4'b0000, 1'b0, t1, 8'h45, 3'b011, 2'd2, 1'b1, 1'b0, "pre_rst_grant2");
        add(1'b1, 4'b0100, 4'b0000, 1'b0, t1, 8'h55, 3'b000, 2'd0, 1'b0, 1'b0, "rst_in_settle");
        add(1'b0, 4'b1001, 4'b0000, 1'b0, t1, 8'h14, 3'b010, 2'd0, 1'b1, 1'b0, "ptr0_grant0");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h54, 3'b010, 2'd0, 1'b1, 1'b0, "ptr0_settle");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h55, 3'b010, 2'd0, 1'b1, 1'b0, "ptr0_occ");
        add(1'b0, 4'b0000, 4'b0001, 1'b0, t1, 8'h55, 3'b010, 2'd0, 1'b0, 1'b0, "ptr0_exit");
        // foreign exit while train 3 occupies
        add(1'b0, 4'b1000, 4'b0000, 1'b0, t1, 8'h15, 3'b101, 2'd3, 1'b1, 1'b0, "fx_grant3");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h15, 3'b101, 2'd3, 1'b1, 1'b0, "fx_settle3");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, t1, 8'h55, 3'b101, 2'd3, 1'b1, 1'b0, "fx_occ3");
        add(1'b0, 4'b0000, 4'b0001, 1'b0, t1, 8'h00, 3'b101, 2'd3, 1'b0, 1'b1, "foreign_exit");
        add(1'b0, 4'b0000, 4'b0000, 1'b1, t1, 8'h55, 3'b101, 2'd3, 1'b0, 1'b0, "fx_clr");
        // ignored exits in IDLE/SETTLE, late table change, exit beats timeout
        add(1'b0, 4'b1000, 4'b1111, 1'b0, t1, 8'h15, 3'b101, 2'd3, 1'b1, 1'b0, "idle_exit_ignored");
        add(1'b0, 4'b0000, 4'b0111, 1'b0, t2, 8'h15, 3'b101, 2'd3, 1'b1, 1'b0, "settle_exit_ignored");
        add(1'b0, 4'b0000, 4'b1000, 1'b1, t2, 8'h55, 3'b101, 2'd3, 1'b1, 1'b0, "settle_own_exit_ignored");
        for (int i = 0; i < TO - 1; i++)
            add(1'b0, 4'b0000, 4'b0000, 1'b0, t2, 8'h55, 3'b101, 2'd3, 1'b1, 1'b0, "ebt_occ");
        add(1'b0, 4'b0000, 4'b1000, 1'b0, t2, 8'h55, 3'b101, 2'd3, 1'b0, 1'b0, "exit_beats_timeout");

        foreach (vq[i]) begin
            apply_edge(vq[i].rst, vq[i].req, vq[i].ex, vq[i].clr, vq[i].tbl);
            check(vq[i].name, {D, SW, GRANT_ID, BUSY, FAULT},
                  {vq[i].d, vq[i].sw, vq[i].gid, vq[i].busy, vq[i].flt});
        end

        // randomized traffic against the reference model
        tbl = t1;
        model_edge(1'b1, 4'b0000, 4'b0000, 1'b0, tbl, exp);
        apply_edge(1'b1, 4'b0000, 4'b0000, 1'b0, tbl);
        check("rand_reset", {D, SW, GRANT_ID, BUSY, FAULT}, exp);
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < N; b++) rq[b] = ($urandom_range(0, 3) == 0);
            ex = 4'b0000;
            if ($urandom_range(0, 5) == 0) ex = 4'b0001 << m_grant;
            if ($urandom_range(0, 59) == 0) ex = ex | (4'b0001 << $urandom_range(0, 3));
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) tbl = 12'($urandom);
            model_edge(rst, rq, ex, clr, tbl, exp);
            apply_edge(rst, rq, ex, clr, tbl);
            check("random", {D, SW, GRANT_ID, BUSY, FAULT}, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
